// File: rtl/pocq_pkg.sv
// Shared HN-F definitions: request flit layout, CHI request opcodes and the
// default POC queue depth.
package pocq_pkg;

  localparam int POCQ_DEPTH = 8;

  localparam logic [5:0] REQ_OP_READSHARED    = 6'h01;
  localparam logic [5:0] REQ_OP_READUNIQUE    = 6'h07;
  localparam logic [5:0] REQ_OP_WRITEBACKFULL = 6'h1B;

  typedef struct packed {
    logic [3:0]  qos;
    logic [6:0]  tgt_id;
    logic [6:0]  src_id;
    logic [7:0]  txn_id;
    logic [5:0]  opcode;
    logic [2:0]  size;
    logic [47:0] addr;
  } reqflit_t;

  localparam int REQFLIT_W = $bits(reqflit_t);

endpackage

// File: rtl/pocq_fifo.sv
// Synchronous FIFO: entry storage plus wrapping read/write pointers.
// Occupancy is tracked by a counter, so full and empty both come from it.
module hnf_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_s;
  logic             pop_s;

  assign empty   = (count_r == CW'(0));
  assign full    = (count_r == CW'(DEPTH));
  assign push_s  = wr_en & ~full;
  assign pop_s   = rd_en & ~empty;
  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;

  // Entry storage; intentionally not reset, contents only matter while counted.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/pocq.sv
// Point-of-coherence request queue: buffers RXREQ flits in arrival order for
// the snoop-filter lookup stage and returns link credits as entries drain.
module pocq
  import pocq_pkg::*;
#(
  parameter int DEPTH = POCQ_DEPTH,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rxreqflitv,
  input  reqflit_t      rxreqflit,
  output logic          rxreq_lcrdv,
  input  logic          pocq_deq,
  output reqflit_t      rxreq_pocq_first_entry,
  output logic          rxreq_pocq_first_entry_v,
  output logic [CW-1:0] pocq_count,
  output logic          pocq_err
);

  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic          deq_s;
  logic          ovf_s;
  logic          crd_issue_s;
  logic [CW-1:0] crd_pend_r;
  logic          lcrdv_r;
  logic          err_r;

  // A dequeue only counts against a valid head; a flit arriving when full is lost.
  assign deq_s       = pocq_deq & ~fifo_empty_s;
  assign ovf_s       = rxreqflitv & fifo_full_s;
  assign crd_issue_s = (crd_pend_r != CW'(0));

  hnf_sync_fifo #(
    .WIDTH (REQFLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (rxreqflitv),
    .wr_data (rxreqflit),
    .rd_en   (pocq_deq),
    .rd_data (rxreq_pocq_first_entry),
    .count   (pocq_count),
    .empty   (fifo_empty_s),
    .full    (fifo_full_s)
  );

  assign rxreq_pocq_first_entry_v = ~fifo_empty_s;

  // Credit return: one credit per cycle while owed; each drained entry owes one more.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crd_pend_r <= CW'(DEPTH);
      lcrdv_r    <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      lcrdv_r    <= crd_issue_s;
      crd_pend_r <= crd_pend_r - CW'(crd_issue_s) + CW'(deq_s);
      if (ovf_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign rxreq_lcrdv = lcrdv_r;
  assign pocq_err    = err_r;

endmodule
